// File: rtl/memory_arbiter_if.sv
// Core-side request/ack ports and memory-side valid/ready port of the memory arbiter.
// The slave view belongs to the arbiter; the master view belongs to the core and memory.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_instr_req;
    logic [ADDR_WIDTH-1:0] i_instr_addr;
    logic                  o_instr_ack;
    logic [DATA_WIDTH-1:0] o_instr_rdata;

    logic                  i_data_req;
    logic                  i_data_we;
    logic [ADDR_WIDTH-1:0] i_data_addr;
    logic [DATA_WIDTH-1:0] i_data_wdata;
    logic                  o_data_ack;
    logic [DATA_WIDTH-1:0] o_data_rdata;

    logic                  o_mem_valid;
    logic                  o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic                  i_mem_ready;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    modport slave (
        input  i_instr_req, i_instr_addr,
        output o_instr_ack, o_instr_rdata,
        input  i_data_req, i_data_we, i_data_addr, i_data_wdata,
        output o_data_ack, o_data_rdata,
        output o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_ready, i_mem_rdata
    );

    modport master (
        output i_instr_req, i_instr_addr,
        input  o_instr_ack, o_instr_rdata,
        output i_data_req, i_data_we, i_data_addr, i_data_wdata,
        input  o_data_ack, o_data_rdata,
        input  o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_ready, i_mem_rdata
    );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and data access.
// Data wins by default; a bounded data streak guarantees fetch progress.
module memory_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input logic             i_clk,
    input logic             i_reset_n,
    memory_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_INSTR,
        GRANT_DATA,
        RESPOND
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  instr_ack_q, instr_ack_d;
    logic [DATA_WIDTH-1:0] instr_rdata_q, instr_rdata_d;
    logic                  data_ack_q, data_ack_d;
    logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
    logic                  instr_wins;

    assign bus.o_mem_valid   = mem_valid_q;
    assign bus.o_mem_we      = mem_we_q;
    assign bus.o_mem_addr    = mem_addr_q;
    assign bus.o_mem_wdata   = mem_wdata_q;
    assign bus.o_instr_ack   = instr_ack_q;
    assign bus.o_instr_rdata = instr_rdata_q;
    assign bus.o_data_ack    = data_ack_q;
    assign bus.o_data_rdata  = data_rdata_q;

    // Fetch only overtakes a pending data request once the streak is exhausted
    assign instr_wins = bus.i_instr_req &&
                        (!bus.i_data_req || streak_q == STREAK_MAX);

    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        mem_valid_d   = mem_valid_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        instr_ack_d   = 1'b0;
        instr_rdata_d = instr_rdata_q;
        data_ack_d    = 1'b0;
        data_rdata_d  = data_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (instr_wins) begin
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.i_instr_addr;
                    mem_wdata_d = '0;
                    streak_d    = '0;
                    state_d     = GRANT_INSTR;
                end else if (bus.i_data_req) begin
                    mem_valid_d = 1'b1;
                    mem_we_d    = bus.i_data_we;
                    mem_addr_d  = bus.i_data_addr;
                    mem_wdata_d = bus.i_data_wdata;
                    if (!bus.i_instr_req)
                        streak_d = '0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = streak_q + 1'b1;
                    state_d = GRANT_DATA;
                end
            end
            GRANT_INSTR: begin
                if (bus.i_mem_ready) begin
                    mem_valid_d   = 1'b0;
                    instr_rdata_d = bus.i_mem_rdata;
                    instr_ack_d   = 1'b1;
                    state_d       = RESPOND;
                end
            end
            GRANT_DATA: begin
                if (bus.i_mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (!mem_we_q)
                        data_rdata_d = bus.i_mem_rdata;
                    data_ack_d = 1'b1;
                    state_d    = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= IDLE;
            streak_q      <= '0;
            mem_valid_q   <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            instr_ack_q   <= 1'b0;
            instr_rdata_q <= '0;
            data_ack_q    <= 1'b0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            mem_valid_q   <= mem_valid_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            instr_ack_q   <= instr_ack_d;
            instr_rdata_q <= instr_rdata_d;
            data_ack_q    <= data_ack_d;
            data_rdata_q  <= data_rdata_d;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, fetch, priority, streak limit,
// store and reset-during-grant scenarios with hand-computed expectations.
module tb_memory_arbiter;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    memory_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_DATA_STREAK(2)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait memory: ready follows valid, read data derived from address
    task automatic step_mem();
        @(negedge clk);
        bus.i_mem_ready = bus.o_mem_valid;
        bus.i_mem_rdata = bus.o_mem_addr ^ K;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.i_instr_req = i[0];
            bus.i_data_req  = ~i[0];
            bus.i_instr_addr = 32'h10;
            bus.i_data_addr  = 32'h100;
        end
        @(negedge clk);
        vectors++;
        if ({bus.o_mem_valid, bus.o_mem_we, bus.o_instr_ack, bus.o_data_ack} !== 4'b0 ||
            bus.o_mem_addr !== 32'h0 || bus.o_mem_wdata !== 32'h0 ||
            bus.o_instr_rdata !== 32'h0 || bus.o_data_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b we=%b addr=%h got nonzero, want all 0",
                     bus.o_mem_valid, bus.o_mem_we, bus.o_mem_addr);
        end
        bus.i_instr_req = 1'b0;
        bus.i_data_req  = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.o_mem_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_no_req: o_mem_valid=%b want 0", bus.o_mem_valid);
            end
        end
    endtask

    task automatic test_fetch();
        @(negedge clk);
        bus.i_instr_addr = 32'h10;
        bus.i_instr_req  = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.o_mem_valid !== 1'b1 || bus.o_mem_addr !== 32'h10 || bus.o_mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_grant: valid=%b addr=%h we=%b want 1 00000010 0",
                     bus.o_mem_valid, bus.o_mem_addr, bus.o_mem_we);
        end
        @(negedge clk);
        vectors++;
        if (bus.o_mem_valid !== 1'b1 || bus.o_instr_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_wait: valid=%b ack=%b want 1 0",
                     bus.o_mem_valid, bus.o_instr_ack);
        end
        bus.i_mem_ready = 1'b1;
        bus.i_mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.i_mem_ready = 1'b0;
        vectors++;
        if (bus.o_instr_ack !== 1'b1 || bus.o_instr_rdata !== 32'hDEAD_BEEF ||
            bus.o_mem_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_ack: ack=%b rdata=%h valid=%b want 1 deadbeef 0",
                     bus.o_instr_ack, bus.o_instr_rdata, bus.o_mem_valid);
        end
        bus.i_instr_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.o_instr_ack !== 1'b0 || bus.o_instr_rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL fetch_ack_pulse: ack=%b rdata=%h want 0 deadbeef",
                     bus.o_instr_ack, bus.o_instr_rdata);
        end
    endtask

    task automatic test_priority();
        int order[$];
        int overlaps;
        @(negedge clk);
        bus.i_instr_addr = 32'h20;
        bus.i_data_addr  = 32'h200;
        bus.i_data_we    = 1'b0;
        bus.i_instr_req  = 1'b1;
        bus.i_data_req   = 1'b1;
        overlaps = 0;
        for (int c = 0; c < 30 && order.size() < 2; c++) begin
            step_mem();
            if (bus.o_instr_ack && bus.o_data_ack) overlaps++;
            if (bus.o_data_ack) begin
                order.push_back(0);
                bus.i_data_req = 1'b0;
            end
            if (bus.o_instr_ack) begin
                order.push_back(1);
                bus.i_instr_req = 1'b0;
            end
        end
        bus.i_instr_req = 1'b0;
        bus.i_data_req  = 1'b0;
        vectors++;
        if (order.size() != 2) begin
            miscompares++;
            $display("FAIL prio_timeout: acks seen=%0d want 2", order.size());
        end else begin
            vectors++;
            if (order[0] != 0 || order[1] != 1) begin
                miscompares++;
                $display("FAIL prio_order: first=%0d second=%0d want 0(data) 1(instr)",
                         order[0], order[1]);
            end
        end
        vectors++;
        if (overlaps != 0) begin
            miscompares++;
            $display("FAIL prio_ack_overlap: overlapping cycles=%0d want 0", overlaps);
        end
        vectors++;
        if (bus.o_data_rdata !== 32'hA5A5_0200 || bus.o_instr_rdata !== 32'hA5A5_0020) begin
            miscompares++;
            $display("FAIL prio_rdata: data=%h instr=%h want a5a50200 a5a50020",
                     bus.o_data_rdata, bus.o_instr_rdata);
        end
        step_mem();
    endtask

    task automatic test_streak();
        logic [5:0] exp_seq;
        logic [5:0] got_seq;
        int n;
        int overlaps;
        exp_seq  = 6'b100100;
        got_seq  = '0;
        n        = 0;
        overlaps = 0;
        @(negedge clk);
        bus.i_instr_addr = 32'h40;
        bus.i_data_addr  = 32'h400;
        bus.i_data_we    = 1'b0;
        bus.i_instr_req  = 1'b1;
        bus.i_data_req   = 1'b1;
        for (int c = 0; c < 60 && n < 6; c++) begin
            step_mem();
            if (bus.o_instr_ack && bus.o_data_ack) overlaps++;
            if (bus.o_mem_valid) begin
                got_seq[n] = (bus.o_mem_addr == 32'h40);
                n++;
            end
        end
        bus.i_instr_req = 1'b0;
        bus.i_data_req  = 1'b0;
        vectors++;
        if (n != 6) begin
            miscompares++;
            $display("FAIL streak_timeout: grants seen=%0d want 6", n);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got_seq[i] !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL streak_grant%0d: got %s want %s", i,
                         got_seq[i] ? "I" : "D", exp_seq[i] ? "I" : "D");
            end
        end
        vectors++;
        if (overlaps != 0) begin
            miscompares++;
            $display("FAIL streak_ack_overlap: overlapping cycles=%0d want 0", overlaps);
        end
        for (int i = 0; i < 4; i++) step_mem();
    endtask

    task automatic test_store();
        bit granted;
        bit acked;
        granted = 1'b0;
        acked   = 1'b0;
        @(negedge clk);
        bus.i_data_addr  = 32'h100;
        bus.i_data_wdata = 32'h1234_5678;
        bus.i_data_we    = 1'b1;
        bus.i_data_req   = 1'b1;
        for (int c = 0; c < 20 && !acked; c++) begin
            step_mem();
            if (bus.o_mem_valid && !granted) begin
                granted = 1'b1;
                vectors++;
                if (bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== 32'h100 ||
                    bus.o_mem_wdata !== 32'h1234_5678) begin
                    miscompares++;
                    $display("FAIL store_grant: we=%b addr=%h wdata=%h want 1 00000100 12345678",
                             bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata);
                end
            end
            if (bus.o_data_ack) begin
                acked = 1'b1;
                bus.i_data_req = 1'b0;
                vectors++;
                if (bus.o_data_rdata !== 32'hA5A5_0400) begin
                    miscompares++;
                    $display("FAIL store_rdata_kept: rdata=%h want a5a50400", bus.o_data_rdata);
                end
            end
        end
        bus.i_data_req = 1'b0;
        bus.i_data_we  = 1'b0;
        vectors++;
        if (!acked) begin
            miscompares++;
            $display("FAIL store_ack_timeout: ack seen=0 want 1");
        end
        step_mem();
    endtask

    task automatic test_reset_in_grant();
        int data_acks;
        bit first_seen;
        bit acked;
        data_acks  = 0;
        first_seen = 1'b0;
        acked      = 1'b0;
        @(negedge clk);
        bus.i_mem_ready  = 1'b0;
        bus.i_instr_addr = 32'h80;
        bus.i_data_addr  = 32'h800;
        bus.i_data_we    = 1'b0;
        bus.i_instr_req  = 1'b1;
        bus.i_data_req   = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.o_mem_valid !== 1'b1 || bus.o_mem_addr !== 32'h800) begin
            miscompares++;
            $display("FAIL rst_grant_data: valid=%b addr=%h want 1 00000800",
                     bus.o_mem_valid, bus.o_mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_data_req = 1'b0;
        #1;
        vectors++;
        if (bus.o_mem_valid !== 1'b0 || bus.o_data_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async_drop: valid=%b ack=%b want 0 0",
                     bus.o_mem_valid, bus.o_data_ack);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20 && !acked; c++) begin
            step_mem();
            if (bus.o_data_ack) data_acks++;
            if (bus.o_mem_valid && !first_seen) begin
                first_seen = 1'b1;
                vectors++;
                if (bus.o_mem_addr !== 32'h80 || bus.o_mem_we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rst_instr_grant: addr=%h we=%b want 00000080 0",
                             bus.o_mem_addr, bus.o_mem_we);
                end
            end
            if (bus.o_instr_ack) begin
                acked = 1'b1;
                bus.i_instr_req = 1'b0;
                vectors++;
                if (bus.o_instr_rdata !== 32'hA5A5_0080) begin
                    miscompares++;
                    $display("FAIL rst_instr_rdata: rdata=%h want a5a50080", bus.o_instr_rdata);
                end
            end
        end
        bus.i_instr_req = 1'b0;
        vectors++;
        if (!acked) begin
            miscompares++;
            $display("FAIL rst_instr_timeout: ack seen=0 want 1");
        end
        vectors++;
        if (data_acks != 0) begin
            miscompares++;
            $display("FAIL rst_no_data_ack: data acks=%0d want 0", data_acks);
        end
        step_mem();
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst_n            = 1'b0;
        bus.i_instr_req  = 1'b0;
        bus.i_instr_addr = '0;
        bus.i_data_req   = 1'b0;
        bus.i_data_we    = 1'b0;
        bus.i_data_addr  = '0;
        bus.i_data_wdata = '0;
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rdata  = '0;
        test_reset();
        test_fetch();
        test_priority();
        test_streak();
        test_store();
        test_reset_in_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
